// File: rtl/ibex_load_resp_unit.sv
// Load/store response unit: tracks outstanding bus requests, merges split beats and
// aligns/extends load data for writeback. Optional error statistics: IBEX_LOAD_RESP_ERR_STATS_EN.
module ibex_load_resp_unit #(
    parameter bit          ResetAll         = 1'b0,
    parameter int unsigned OutstandingDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_push_i,
    input  logic        req_is_load_i,
    input  logic [1:0]  req_type_i,
    input  logic        req_sign_ext_i,
    input  logic [1:0]  req_offset_i,
    input  logic        req_split_i,
    output logic        req_full_o,
    output logic        outstanding_o,

    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,

    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic [7:0]  err_count_o
);

    localparam logic [2:0] DepthCnt = 3'(OutstandingDepth);
    localparam logic [1:0] LastPtr  = 2'(OutstandingDepth - 1);

    localparam logic [0:0] IDLE        = 1'b0;
    localparam logic [0:0] WAIT_SECOND = 1'b1;

    typedef struct packed {
        logic       is_load;
        logic [1:0] typ;
        logic       sign_ext;
        logic [1:0] offset;
        logic       split;
    } rec_t;

    // Storage is sized for the largest legal depth; pointers only visit 0..Depth-1.
    rec_t        fifo_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [0:0]  state_q, state_d;
    logic [31:0] rdata_q;
    logic        err_q;

    rec_t        head;
    rec_t        push_rec;
    logic        fifo_empty;
    logic        fifo_full;
    logic        beat_ok;
    logic        capture;
    logic        complete;
    logic        push_acc;
    logic [31:0] raw;
    logic        resp_err;
    logic        resp_we;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LastPtr) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] r,
                                           input logic [1:0]  typ,
                                           input logic        sext);
        case (typ)
            2'b01:   return {{16{sext & r[15]}}, r[15:0]};
            2'b10:   return {{24{sext & r[7]}}, r[7:0]};
            default: return r;
        endcase
    endfunction

    assign push_rec = '{is_load:  req_is_load_i,
                        typ:      req_type_i,
                        sign_ext: req_sign_ext_i,
                        offset:   req_offset_i,
                        split:    req_split_i};

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == DepthCnt);
    assign head       = fifo_q[rd_ptr_q];

    // A response with nothing outstanding is ignored entirely.
    assign beat_ok  = data_rvalid_i & ~fifo_empty;
    assign capture  = beat_ok & head.split & (state_q == IDLE);
    assign complete = beat_ok & ~capture;
    assign push_acc = req_push_i & (~fifo_full | complete);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        state_d  = state_q;
        if (complete) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            state_d  = IDLE;
        end
        if (capture) begin
            state_d = WAIT_SECOND;
        end
        if (push_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        count_d = count_q + {2'b00, push_acc} - {2'b00, complete};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            state_q  <= IDLE;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    generate
        if (ResetAll) begin : g_payload_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < 4; i++) begin
                        fifo_q[i] <= '0;
                    end
                    rdata_q <= 32'd0;
                    err_q   <= 1'b0;
                end else begin
                    if (push_acc) begin
                        fifo_q[wr_ptr_q] <= push_rec;
                    end
                    if (capture) begin
                        rdata_q <= data_rdata_i;
                        err_q   <= data_err_i;
                    end
                end
            end
        end else begin : g_payload_norst
            always_ff @(posedge clk_i) begin
                if (push_acc) begin
                    fifo_q[wr_ptr_q] <= push_rec;
                end
                if (capture) begin
                    rdata_q <= data_rdata_i;
                    err_q   <= data_err_i;
                end
            end
        end
    endgenerate

    // Split accesses read a 64-bit window {second beat, first beat} starting at the offset.
    always_comb begin
        if (head.split) begin
            case (head.offset)
                2'd1:    raw = {data_rdata_i[7:0],  rdata_q[31:8]};
                2'd2:    raw = {data_rdata_i[15:0], rdata_q[31:16]};
                2'd3:    raw = {data_rdata_i[23:0], rdata_q[31:24]};
                default: raw = rdata_q;
            endcase
        end else begin
            raw = data_rdata_i >> {head.offset, 3'b000};
        end
    end

    assign resp_err = complete & (data_err_i | (head.split & err_q));
    assign resp_we  = complete & head.is_load & ~resp_err;

    assign lsu_resp_valid_o = complete;
    assign lsu_resp_err_o   = resp_err;
    assign rf_we_lsu_o      = resp_we;
    assign rf_wdata_lsu_o   = resp_we ? extend(raw, head.typ, head.sign_ext) : 32'd0;

    assign req_full_o    = fifo_full;
    assign outstanding_o = ~fifo_empty;

`ifdef IBEX_LOAD_RESP_ERR_STATS_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (complete && resp_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count_o = err_cnt_q;
`else
    assign err_count_o = 8'd0;
`endif

`ifndef SYNTHESIS
    a_rvalid_outstanding : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(data_rvalid_i && fifo_empty))
        else $warning("data_rvalid_i with no outstanding request, response ignored");

    a_push_not_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_push_i && fifo_full && !complete))
        else $warning("request push while record FIFO full, push dropped");
`endif

endmodule

// File: tb/tb_ibex_load_resp_unit.sv
// Scoreboard bench for ibex_load_resp_unit: byte-level reference model, directed and random traffic.
module tb_ibex_load_resp_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_push, req_is_load, req_sign_ext, req_split;
    logic [1:0]  req_type, req_offset;
    logic        req_full, outstanding;
    logic        rvalid, rerr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        we, resp_valid, resp_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    ibex_load_resp_unit dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_push_i       (req_push),
        .req_is_load_i    (req_is_load),
        .req_type_i       (req_type),
        .req_sign_ext_i   (req_sign_ext),
        .req_offset_i     (req_offset),
        .req_split_i      (req_split),
        .req_full_o       (req_full),
        .outstanding_o    (outstanding),
        .data_rvalid_i    (rvalid),
        .data_rdata_i     (rdata),
        .data_err_i       (rerr),
        .rf_wdata_lsu_o   (wdata),
        .rf_we_lsu_o      (we),
        .lsu_resp_valid_o (resp_valid),
        .lsu_resp_err_o   (resp_err),
        .err_count_o      (err_count)
    );

    typedef struct {
        bit       ld;
        bit [1:0] typ;
        bit       sx;
        bit [1:0] off;
        bit       split;
    } rec_t;

    typedef struct {
        bit [31:0] wdata;
        bit        we;
        bit        err;
    } exp_t;

    rec_t      pend[$];
    exp_t      expq[$];
    int        checks = 0;
    int        errors = 0;
    int        ecnt   = 0;
    bit        in2    = 0;
    bit [31:0] b1;
    bit        e1;
    bit        lit_en = 0;
    exp_t      lit;

    function automatic rec_t mkrec(bit ld, bit [1:0] typ, bit sx, bit [1:0] off);
        rec_t r;
        r.ld    = ld;
        r.typ   = typ;
        r.sx    = sx;
        r.off   = off;
        r.split = ((typ == 2'b00 || typ == 2'b11) && off != 2'd0) || (typ == 2'b01 && off == 2'd3);
        return r;
    endfunction

    // Reference: lay the beats out as a byte stream and pick bytes starting at the offset.
    function automatic exp_t model(rec_t h, bit [31:0] first, bit ferr, bit [31:0] last, bit lerr);
        bit [7:0]  by [8];
        int        n;
        bit [31:0] v;
        exp_t      r;
        for (int i = 0; i < 4; i++) begin
            by[i]     = h.split ? first[8*i +: 8] : last[8*i +: 8];
            by[i + 4] = h.split ? last[8*i +: 8] : 8'h00;
        end
        n = (h.typ == 2'b01) ? 2 : (h.typ == 2'b10) ? 1 : 4;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(by[int'(h.off) + i]) << (8 * i));
        if (h.sx && n < 4 && by[int'(h.off) + n - 1][7])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        r.err   = lerr | (h.split & ferr);
        r.we    = h.ld & !r.err;
        r.wdata = r.we ? v : 32'd0;
        return r;
    endfunction

    task automatic chk(input string name, input bit [31:0] act, input bit [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock of stimulus; model state advances at the same edge as the DUT.
    task automatic cyc(input bit push, input rec_t r, input bit rv, input bit [31:0] rd, input bit er);
        bit   comp = 0;
        bit   cap  = 0;
        exp_t e;
        req_push     = push;
        req_is_load  = r.ld;
        req_type     = r.typ;
        req_sign_ext = r.sx;
        req_offset   = r.off;
        req_split    = r.split;
        rvalid       = rv;
        rdata        = rd;
        rerr         = er;
        if (rv && pend.size() != 0) begin
            if (pend[0].split && !in2) cap = 1;
            else                       comp = 1;
            if (comp) begin
                e = model(pend[0], b1, e1, rd, er);
                if (lit_en) begin
                    e      = lit;
                    lit_en = 0;
                end
                expq.push_back(e);
            end
        end
        @(posedge clk);
        if (comp) begin
            void'(pend.pop_front());
            in2 = 0;
`ifdef IBEX_LOAD_RESP_ERR_STATS_EN
            if (e.err && ecnt < 255) ecnt++;
`endif
        end
        if (cap) begin
            in2 = 1;
            b1  = rd;
            e1  = er;
        end
        if (push && pend.size() < DEPTH) pend.push_back(r);
        #1;
        req_push = 0;
        rvalid   = 0;
    endtask

    task automatic expect_lit(input bit [31:0] wd, input bit w, input bit er);
        lit.wdata = wd;
        lit.we    = w;
        lit.err   = er;
        lit_en    = 1;
    endtask

    // Monitor: compares every presented response against the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (resp_valid) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp actual wdata=%h we=%0d err=%0d required none", wdata, we, resp_err);
                    end else begin
                        e = expq.pop_front();
                        chk("resp_wdata", wdata, e.wdata);
                        chk("resp_we", 32'(we), 32'(e.we));
                        chk("resp_err", 32'(resp_err), 32'(e.err));
                    end
                end else begin
                    chk("idle_we", 32'(we), 0);
                    chk("idle_err", 32'(resp_err), 0);
                    chk("idle_wdata", wdata, 0);
                end
                chk("outstanding", 32'(outstanding), 32'(pend.size() != 0));
                chk("full", 32'(req_full), 32'(pend.size() == DEPTH));
                chk("err_count", 32'(err_count), ecnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t nr;
        rec_t r;
        nr = mkrec(0, 0, 0, 0);
        rst_n = 0; req_push = 0; req_is_load = 0; req_type = 0; req_sign_ext = 0;
        req_offset = 0; req_split = 0; rvalid = 0; rdata = 0; rerr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_full", 32'(req_full), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_err_count", 32'(err_count), 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Byte load, sign-extended, offset 2
        cyc(1, mkrec(1, 2'b10, 1, 2), 0, 0, 0);
        expect_lit(32'hFFFFFF80, 1, 0);
        cyc(0, nr, 1, 32'h12803456, 0);

        // Split word load, offset 1
        cyc(1, mkrec(1, 2'b00, 0, 1), 0, 0, 0);
        cyc(0, nr, 1, 32'hAABBCCDD, 0);
        expect_lit(32'h44AABBCC, 1, 0);
        cyc(0, nr, 1, 32'h11223344, 0);

        // Split load with error on first beat
        cyc(1, mkrec(1, 2'b00, 0, 2), 0, 0, 0);
        cyc(0, nr, 1, 32'hCAFEF00D, 1);
        expect_lit(32'h0, 0, 1);
        cyc(0, nr, 1, 32'h01234567, 0);

        // Store completion
        cyc(1, mkrec(0, 2'b00, 0, 0), 0, 0, 0);
        expect_lit(32'h0, 0, 0);
        cyc(0, nr, 1, 32'hDEADBEEF, 0);

        // Fill, dropped push, push coinciding with pop, drain
        cyc(1, mkrec(1, 2'b00, 0, 0), 0, 0, 0);
        cyc(1, mkrec(1, 2'b01, 1, 2), 0, 0, 0);
        cyc(1, mkrec(1, 2'b10, 0, 1), 0, 0, 0);
        cyc(1, mkrec(1, 2'b10, 1, 3), 1, 32'h01020304, 0);
        cyc(0, nr, 1, 32'h8765ABCD, 0);
        cyc(0, nr, 1, 32'h80FF1234, 0);
        cyc(0, nr, 0, 0, 0);

        // Response with nothing outstanding
        cyc(0, nr, 1, 32'h55555555, 1);

        // Reset in the middle of a split access
        cyc(1, mkrec(1, 2'b01, 1, 3), 0, 0, 0);
        cyc(0, nr, 1, 32'h9ABCDEF0, 0);
        rst_n = 0;
        pend.delete();
        in2  = 0;
        ecnt = 0;
        @(negedge clk);
        chk("midrst_outstanding", 32'(outstanding), 0);
        chk("midrst_valid", 32'(resp_valid), 0);
        @(posedge clk); #1;
        rst_n = 1;
        cyc(1, mkrec(1, 2'b01, 1, 3), 0, 0, 0);
        cyc(0, nr, 1, 32'h80000000, 0);
        cyc(0, nr, 1, 32'h000000FF, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit pu, rv;
            r  = mkrec($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1), 2'($urandom_range(0, 3)));
            rv = (pend.size() != 0) && ($urandom_range(0, 9) < 6);
            pu = ($urandom_range(0, 1) == 1) && (pend.size() < DEPTH);
            cyc(pu, r, rv, $urandom, ($urandom_range(0, 7) == 0));
        end
        while (pend.size() != 0) cyc(0, nr, 1, $urandom, 0);

        // Error completions to exercise counter saturation
        ecnt = ecnt;
        cyc(1, mkrec(1, 2'b00, 0, 0), 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, mkrec(1, 2'b00, 0, 0), 1, $urandom, 1);
        cyc(0, nr, 1, $urandom, 1);
        cyc(0, nr, 0, 0, 0);
`ifdef IBEX_LOAD_RESP_ERR_STATS_EN
        chk("err_count_sat", 32'(err_count), 255);
`else
        chk("err_count_tied", 32'(err_count), 0);
`endif

        chk("scoreboard_empty", 32'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
